// File: rtl/dec_round_key_gen.sv
// AES-128 round-key generator: expands the cipher key one round per cycle
// into a buffer, then serves round keys from NR down to 0 on request.
module dec_round_key_gen #(
    parameter int KEY_WIDTH = 128,
    parameter int NR        = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [KEY_WIDTH-1:0] key_i,
    input  logic                 key_valid_i,
    output logic                 key_ready_o,
    input  logic                 round_req_i,
    output logic [KEY_WIDTH-1:0] rk_o,
    output logic [3:0]           rk_round_o,
    output logic                 rk_valid_o,
    output logic                 busy_o,
    output logic                 done_o
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXPAND = 2'd1;
    localparam logic [1:0] S_SERVE  = 2'd2;
    localparam logic [3:0] LAST     = 4'(NR);

    logic [1:0]                  state;
    logic [NR:0][KEY_WIDTH-1:0]  rk;
    logic [KEY_WIDTH-1:0]        wk;     // most recently produced round key
    logic [3:0]                  cnt;
    logic [7:0]                  rcon;

    logic [31:0] w0, w1, w2, w3, rot, sub, t, n0, n1, n2, n3;
    logic [KEY_WIDTH-1:0] nk;
    logic [7:0] rcon_nxt;

    assign {w0, w1, w2, w3} = wk;
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        dec_rkg_sbox u_sbox (.a(rot[8*i +: 8]), .s(sub[8*i +: 8]));
    end

    assign t        = sub ^ {rcon, 24'h0};
    assign n0       = w0 ^ t;
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign nk       = {n0, n1, n2, n3};
    assign rcon_nxt = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

    assign key_ready_o = (state == S_IDLE);
    assign busy_o      = (state == S_EXPAND);
    assign rk_valid_o  = (state == S_SERVE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            rk         <= '0;
            wk         <= '0;
            cnt        <= '0;
            rcon       <= 8'h01;
            rk_o       <= '0;
            rk_round_o <= '0;
            done_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: if (key_valid_i) begin
                    rk[0] <= key_i;
                    wk    <= key_i;
                    cnt   <= 4'd1;
                    rcon  <= 8'h01;
                    state <= S_EXPAND;
                end
                S_EXPAND: begin
                    rk[cnt] <= nk;
                    wk      <= nk;
                    cnt     <= cnt + 4'd1;
                    rcon    <= rcon_nxt;
                    // last key goes straight to the output register
                    if (cnt == LAST) begin
                        state      <= S_SERVE;
                        rk_o       <= nk;
                        rk_round_o <= LAST;
                    end
                end
                S_SERVE: if (round_req_i) begin
                    if (rk_round_o != 4'd0) begin
                        rk_round_o <= rk_round_o - 4'd1;
                        rk_o       <= rk[rk_round_o - 4'd1];
                    end else begin
                        state  <= S_IDLE;
                        done_o <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// Forward AES S-box: GF(2^8) inverse (x^254) followed by the affine map.
module dec_rkg_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p, m;
        p = 8'h00;
        m = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ m;
            m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] sq, r;
        sq = x;
        r  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    logic [7:0] b;
    assign b = ginv(a);
    assign s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
endmodule

// File: tb/tb_dec_round_key_gen.sv
// Directed bench for dec_round_key_gen using FIPS-197 and zero-key vectors.
module tb_dec_round_key_gen;
    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [127:0] key_i = '0;
    logic         key_valid_i = 1'b0;
    logic         key_ready_o;
    logic         round_req_i = 1'b0;
    logic [127:0] rk_o;
    logic [3:0]   rk_round_o;
    logic         rk_valid_o;
    logic         busy_o;
    logic         done_o;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FIPS_R9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] FIPS_R6  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    localparam logic [127:0] FIPS_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] ZERO_R2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;

    int n_chk = 0;
    int n_fail = 0;

    dec_round_key_gen dut (
        .clk_i(clk_i), .rst_i(rst_i), .key_i(key_i), .key_valid_i(key_valid_i),
        .key_ready_o(key_ready_o), .round_req_i(round_req_i), .rk_o(rk_o),
        .rk_round_o(rk_round_o), .rk_valid_o(rk_valid_o), .busy_o(busy_o),
        .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 128'(key_ready_o), 128'd1);
        chk({tag, "_rk"},    rk_o, '0);
        chk({tag, "_round"}, 128'(rk_round_o), '0);
        chk({tag, "_valid"}, 128'(rk_valid_o), '0);
        chk({tag, "_busy"},  128'(busy_o), '0);
        chk({tag, "_done"},  128'(done_o), '0);
    endtask

    task automatic load(input logic [127:0] k);
        key_i = k;
        key_valid_i = 1'b1;
        step();
        key_valid_i = 1'b0;
    endtask

    // Counts cycles from the accepting edge until rk_valid_o, bounded.
    task automatic wait_serve(input string tag, input logic [127:0] exp_r10);
        int n, nb;
        n = 0;
        nb = 0;
        while (!rk_valid_o && n < 40) begin
            if (busy_o) nb++;
            step();
            n++;
        end
        chk({tag, "_latency"}, 128'(n), 128'd10);
        chk({tag, "_busy_cycles"}, 128'(nb), 128'd10);
        chk({tag, "_round10_idx"}, 128'(rk_round_o), 128'd10);
        chk({tag, "_round10_key"}, rk_o, exp_r10);
    endtask

    task automatic pulse(input int k);
        repeat (k) begin
            round_req_i = 1'b1;
            step();
            round_req_i = 1'b0;
            step();
        end
    endtask

    task automatic drain();
        pulse(int'(rk_round_o) + 1);
        chk("drain_idle", 128'(key_ready_o), 128'd1);
    endtask

    initial begin
        // reset state
        #12;
        chk_reset_outputs("reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        step();

        // 1/2: FIPS key, walk down to round 0 and completion
        load(FIPS_KEY);
        wait_serve("t1", FIPS_R10);
        pulse(1);
        chk("t2_r9", rk_o, FIPS_R9);
        pulse(7);
        chk("t2_r2", rk_o, FIPS_R2);
        pulse(1);
        chk("t2_r1_idx", 128'(rk_round_o), 128'd1);
        chk("t2_r1", rk_o, FIPS_R1);
        pulse(1);
        chk("t2_r0_idx", 128'(rk_round_o), 128'd0);
        chk("t2_r0", rk_o, FIPS_KEY);
        round_req_i = 1'b1;
        step();
        round_req_i = 1'b0;
        chk("t2_done", 128'(done_o), 128'd1);
        chk("t2_ready", 128'(key_ready_o), 128'd1);
        chk("t2_valid", 128'(rk_valid_o), 128'd0);
        chk("t2_hold", rk_o, FIPS_KEY);
        step();
        chk("t2_done_pulse", 128'(done_o), 128'd0);

        // 3: all-zero key
        load('0);
        wait_serve("t3", ZERO_R10);
        pulse(8);
        chk("t3_r2", rk_o, ZERO_R2);
        pulse(1);
        chk("t3_r1", rk_o, ZERO_R1);
        drain();

        // 4: key_valid and round_req held during EXPAND/SERVE are ignored
        load(FIPS_KEY);
        key_i = ~FIPS_KEY;
        key_valid_i = 1'b1;
        round_req_i = 1'b1;
        chk("t4_ready_expand", 128'(key_ready_o), 128'd0);
        wait_serve("t4", FIPS_R10);
        round_req_i = 1'b0;
        pulse(9);
        chk("t4_ready_serve", 128'(key_ready_o), 128'd0);
        chk("t4_r1", rk_o, FIPS_R1);
        key_valid_i = 1'b0;
        drain();

        // 5: async reset in EXPAND cycle 5, then in SERVE at idx 6
        load(FIPS_KEY);
        repeat (4) step();
        chk("t5_busy_pre", 128'(busy_o), 128'd1);
        #2 rst_i = 1'b1;
        #1 chk_reset_outputs("t5_rst_expand");
        step();
        rst_i = 1'b0;
        load(FIPS_KEY);
        wait_serve("t5a", FIPS_R10);
        pulse(4);
        chk("t5_r6", rk_o, FIPS_R6);
        #2 rst_i = 1'b1;
        #1 chk_reset_outputs("t5_rst_serve");
        step();
        rst_i = 1'b0;
        load(FIPS_KEY);
        wait_serve("t5b", FIPS_R10);
        pulse(9);
        chk("t5b_r1", rk_o, FIPS_R1);
        drain();

        // 6: continuous requests, then back-to-back key in the done cycle
        load(FIPS_KEY);
        wait_serve("t6", FIPS_R10);
        round_req_i = 1'b1;
        for (int i = 10; i >= 0; i--) begin
            chk($sformatf("t6_idx%0d", i), 128'(rk_round_o), 128'(i));
            chk($sformatf("t6_vld%0d", i), 128'(rk_valid_o), 128'd1);
            if (i == 9) chk("t6_r9", rk_o, FIPS_R9);
            if (i == 0) chk("t6_r0", rk_o, FIPS_KEY);
            step();
        end
        round_req_i = 1'b0;
        chk("t6_done", 128'(done_o), 128'd1);
        load('0);
        chk("t6_done_clear", 128'(done_o), 128'd0);
        chk("t6_busy", 128'(busy_o), 128'd1);
        wait_serve("t6z", ZERO_R10);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
